// File: rtl/tbuf_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tbuf_bus_pkg
// Purpose  : Shared constants, state encoding and width helper for the
//            tri-state bus arbiter.
// Revision : 1.0  initial release
// ============================================================================
package tbuf_bus_pkg;

    localparam int c_NREQ_DEF      = 4;
    localparam int c_TURN_CYC_DEF  = 1;
    localparam int c_MAX_BURST_DEF = 8;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE  = 2'd0;
    localparam state_t c_ST_GRANT = 2'd1;
    localparam state_t c_ST_TURN  = 2'd2;

    // Width of a counter that has to reach the value n.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int c_BCNT_W_DEF = cnt_w(c_MAX_BURST_DEF);
    localparam int c_TCNT_W_DEF = cnt_w(c_TURN_CYC_DEF);

endpackage
`default_nettype wire

// File: rtl/tbuf_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : tbuf_bus_arbiter_if
// Purpose  : Request / grant / pad-enable bundle between requesters and the
//            tri-state bus arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface tbuf_bus_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] tbuf_en;
    logic            pad_oen;
    logic            busy;
    logic [OW-1:0]   owner;

    modport master (output req, input gnt, tbuf_en, pad_oen, busy, owner);
    modport slave  (input req, output gnt, tbuf_en, pad_oen, busy, owner);
endinterface
`default_nettype wire

// File: rtl/tbuf_bus_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin first-set finder: lowest set request
//            at or above i_rr, wrapping at NREQ.
// Revision : 1.0  initial release
// ============================================================================
module rr_pick
    import tbuf_bus_pkg::*;
#(
    parameter int NREQ = c_NREQ_DEF,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  wire logic [NREQ-1:0] i_req,
    input  wire logic [IW-1:0]   i_rr,
    output logic      [IW-1:0]   o_winner,
    output logic                 o_valid
);

    function automatic logic [IW-1:0] rot_idx(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return IW'(s);
    endfunction

    // Scan from the farthest offset down so the nearest set bit wins last.
    always_comb begin
        o_winner = '0;
        o_valid  = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (i_req[rot_idx(i_rr, k)]) begin
                o_winner = rot_idx(i_rr, k);
                o_valid  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tbuf_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tbuf_bus_arbiter
// Purpose  : Round-robin owner selection for a shared tri-state net with
//            registered one-hot TBUF enables, pad OEN and turnaround gap.
//            Optional bus parking on driver 0: define TBUF_BUS_PARK_EN.
// Revision : 1.0  initial release
// ============================================================================
module tbuf_bus_arbiter
    import tbuf_bus_pkg::*;
#(
    parameter int NREQ      = c_NREQ_DEF,
    parameter int TURN_CYC  = c_TURN_CYC_DEF,
    parameter int MAX_BURST = c_MAX_BURST_DEF
) (
    input wire logic          CK,
    input wire logic          RN,
    tbuf_bus_arbiter_if.slave bus
);

    localparam int OW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BCNT_W = cnt_w(MAX_BURST);
    localparam int TCNT_W = cnt_w(TURN_CYC);

    state_t            r_state,  w_state_nxt;
    logic [NREQ-1:0]   r_gnt,    w_gnt_nxt;
    logic [NREQ-1:0]   r_en,     w_en_nxt;
    logic              r_oen;
    logic              r_busy;
    logic [OW-1:0]     r_owner,  w_owner_nxt;
    logic [OW-1:0]     r_rr,     w_rr_nxt;
    logic [BCNT_W-1:0] r_bcnt,   w_bcnt_nxt;
    logic [TCNT_W-1:0] r_tcnt,   w_tcnt_nxt;
    logic [OW-1:0]     w_winner;
    logic              w_valid;
`ifdef TBUF_BUS_PARK_EN
    logic              r_pend,     w_pend_nxt;
    logic [OW-1:0]     r_pend_idx, w_pend_idx_nxt;
`endif

    function automatic logic [NREQ-1:0] onehot(input logic [OW-1:0] idx);
        logic [NREQ-1:0] v;
        for (int i = 0; i < NREQ; i++) v[i] = (idx == OW'(i));
        return v;
    endfunction

    function automatic logic [OW-1:0] next_rr(input logic [OW-1:0] idx);
        return (idx == OW'(NREQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    rr_pick #(
        .NREQ     (NREQ),
        .IW       (OW)
    ) u_rr_pick (
        .i_req    (bus.req),
        .i_rr     (r_rr),
        .o_winner (w_winner),
        .o_valid  (w_valid)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr;
        w_bcnt_nxt  = r_bcnt;
        w_tcnt_nxt  = r_tcnt;
`ifdef TBUF_BUS_PARK_EN
        w_pend_nxt     = r_pend;
        w_pend_idx_nxt = r_pend_idx;
`endif
        case (r_state)
            c_ST_IDLE: begin
                w_gnt_nxt = '0;
                if (w_valid) begin
                    w_rr_nxt = next_rr(w_winner);
`ifdef TBUF_BUS_PARK_EN
                    // Handing the net from the parked driver 0 to another index
                    // needs a full turnaround before the new driver is enabled.
                    if (w_winner != '0) begin
                        w_state_nxt    = c_ST_TURN;
                        w_tcnt_nxt     = TCNT_W'(1);
                        w_pend_nxt     = 1'b1;
                        w_pend_idx_nxt = w_winner;
                    end else
`endif
                    begin
                        w_state_nxt = c_ST_GRANT;
                        w_gnt_nxt   = onehot(w_winner);
                        w_owner_nxt = w_winner;
                        w_bcnt_nxt  = BCNT_W'(1);
                    end
                end
            end
            c_ST_GRANT: begin
                if (!bus.req[r_owner] || (r_bcnt == BCNT_W'(MAX_BURST))) begin
                    w_state_nxt = c_ST_TURN;
                    w_gnt_nxt   = '0;
                    w_tcnt_nxt  = TCNT_W'(1);
                end else begin
                    w_bcnt_nxt = r_bcnt + 1'b1;
                end
            end
            c_ST_TURN: begin
                w_gnt_nxt = '0;
                if (r_tcnt == TCNT_W'(TURN_CYC)) begin
`ifdef TBUF_BUS_PARK_EN
                    if (r_pend) begin
                        w_state_nxt = c_ST_GRANT;
                        w_gnt_nxt   = onehot(r_pend_idx);
                        w_owner_nxt = r_pend_idx;
                        w_bcnt_nxt  = BCNT_W'(1);
                        w_pend_nxt  = 1'b0;
                    end else
`endif
                    begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end else begin
                    w_tcnt_nxt = r_tcnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_en_nxt = w_gnt_nxt;
`ifdef TBUF_BUS_PARK_EN
        if (w_state_nxt == c_ST_IDLE) w_en_nxt = onehot('0);
`endif
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_state <= c_ST_IDLE;
            r_gnt   <= '0;
            r_en    <= '0;
            r_oen   <= 1'b1;
            r_busy  <= 1'b0;
            r_owner <= '0;
            r_rr    <= '0;
            r_bcnt  <= '0;
            r_tcnt  <= '0;
`ifdef TBUF_BUS_PARK_EN
            r_pend     <= 1'b0;
            r_pend_idx <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_en    <= w_en_nxt;
            r_oen   <= ~|w_en_nxt;
            r_busy  <= (w_state_nxt != c_ST_IDLE);
            r_owner <= w_owner_nxt;
            r_rr    <= w_rr_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_tcnt  <= w_tcnt_nxt;
`ifdef TBUF_BUS_PARK_EN
            r_pend     <= w_pend_nxt;
            r_pend_idx <= w_pend_idx_nxt;
`endif
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.tbuf_en = r_en;
    assign bus.pad_oen = r_oen;
    assign bus.busy    = r_busy;
    assign bus.owner   = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_tbuf_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tbuf_bus_arbiter
// Purpose  : Self-checking vector bench for tbuf_bus_arbiter (NREQ=4,
//            TURN_CYC=1, MAX_BURST=8); park vectors under TBUF_BUS_PARK_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_tbuf_bus_arbiter;

    localparam int NREQ = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tbuf_bus_arbiter_if #(.NREQ(NREQ)) bus_if ();

    tbuf_bus_arbiter #(
        .NREQ      (NREQ),
        .TURN_CYC  (1),
        .MAX_BURST (8)
    ) dut (
        .CK  (clk),
        .RN  (rst_n),
        .bus (bus_if)
    );

    typedef struct {
        logic       rn;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [3:0] en;
        logic       oen;
        logic       busy;
        logic [1:0] owner;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic rn, input logic [3:0] req, input logic [3:0] gnt,
                       input logic [3:0] en, input logic oen, input logic busy,
                       input logic [1:0] owner, input int n);
        vec_t v;
        v = '{rn, req, gnt, en, oen, busy, owner};
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one vector before the edge; compare the scoreboard entry after it.
    task automatic step(input vec_t v, input string tag);
        vec_t e;
        @(negedge clk);
        rst_n      = v.rn;
        bus_if.req = v.req;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".gnt"},   32'(bus_if.gnt),     32'(e.gnt));
        chk({tag, ".en"},    32'(bus_if.tbuf_en), 32'(e.en));
        chk({tag, ".oen"},   32'(bus_if.pad_oen), 32'(e.oen));
        chk({tag, ".busy"},  32'(bus_if.busy),    32'(e.busy));
        chk({tag, ".owner"}, 32'(bus_if.owner),   32'(e.owner));
    endtask

    // Bus-safety invariants sampled away from the active edge.
    always @(negedge clk) begin
        total++;
        assert ($onehot0(bus_if.tbuf_en) && $onehot0(bus_if.gnt)) else begin
            bad++;
            $display("FAIL onehot: gnt=%b en=%b", bus_if.gnt, bus_if.tbuf_en);
        end
        total++;
        assert (bus_if.pad_oen == ~|bus_if.tbuf_en) else begin
            bad++;
            $display("FAIL oen_inv: oen=%b en=%b", bus_if.pad_oen, bus_if.tbuf_en);
        end
`ifndef TBUF_BUS_PARK_EN
        total++;
        assert (bus_if.gnt == bus_if.tbuf_en) else begin
            bad++;
            $display("FAIL gnt_en: gnt=%b en=%b", bus_if.gnt, bus_if.tbuf_en);
        end
`endif
    end

    initial begin
        bus_if.req = '0;
        rst_n      = 1'b0;

`ifdef TBUF_BUS_PARK_EN
        add(0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 2);
        add(1, 4'b0000, 4'b0000, 4'b0001, 0, 0, 0, 2);
        add(1, 4'b1000, 4'b0000, 4'b0000, 1, 1, 0, 1);
        add(1, 4'b1000, 4'b1000, 4'b1000, 0, 1, 3, 1);
        add(1, 4'b0000, 4'b0000, 4'b0000, 1, 1, 3, 1);
        add(1, 4'b0000, 4'b0000, 4'b0001, 0, 0, 3, 1);
        add(1, 4'b0001, 4'b0001, 4'b0001, 0, 1, 0, 1);
        add(1, 4'b0000, 4'b0000, 4'b0000, 1, 1, 0, 1);
        add(1, 4'b0000, 4'b0000, 4'b0001, 0, 0, 0, 1);
`else
        // Reset held with all requests up, then release.
        add(0, 4'b1111, 4'b0000, 4'b0000, 1, 0, 0, 3);
        add(1, 4'b1111, 4'b0001, 4'b0001, 0, 1, 0, 1);
        add(1, 4'b0000, 4'b0000, 4'b0000, 1, 1, 0, 1);
        add(1, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 1);
        // Round robin between 1 and 3, full bursts.
        add(1, 4'b1010, 4'b0010, 4'b0010, 0, 1, 1, 8);
        add(1, 4'b1010, 4'b0000, 4'b0000, 1, 1, 1, 1);
        add(1, 4'b1010, 4'b0000, 4'b0000, 1, 0, 1, 1);
        add(1, 4'b1010, 4'b1000, 4'b1000, 0, 1, 3, 8);
        add(1, 4'b1010, 4'b0000, 4'b0000, 1, 1, 3, 1);
        add(1, 4'b1010, 4'b0000, 4'b0000, 1, 0, 3, 1);
        add(1, 4'b1010, 4'b0010, 4'b0010, 0, 1, 1, 1);
        add(1, 4'b0000, 4'b0000, 4'b0000, 1, 1, 1, 1);
        add(1, 4'b0000, 4'b0000, 4'b0000, 1, 0, 1, 1);
        // Early release of requester 2.
        add(1, 4'b0100, 4'b0100, 4'b0100, 0, 1, 2, 3);
        add(1, 4'b0000, 4'b0000, 4'b0000, 1, 1, 2, 1);
        add(1, 4'b0000, 4'b0000, 4'b0000, 1, 0, 2, 1);
        // Single requester hitting the burst limit twice (period 10).
        for (int p = 0; p < 2; p++) begin
            add(1, 4'b0001, 4'b0001, 4'b0001, 0, 1, 0, 8);
            add(1, 4'b0001, 4'b0000, 4'b0000, 1, 1, 0, 1);
            add(1, 4'b0001, 4'b0000, 4'b0000, 1, 0, 0, 1);
        end
        add(1, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 1);
        // Request drop coinciding with the burst limit: one release only.
        add(1, 4'b0010, 4'b0010, 4'b0010, 0, 1, 1, 8);
        add(1, 4'b0000, 4'b0000, 4'b0000, 1, 1, 1, 1);
        add(1, 4'b0000, 4'b0000, 4'b0000, 1, 0, 1, 1);
        add(1, 4'b0100, 4'b0100, 4'b0100, 0, 1, 2, 2);
`endif

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("v%0d", i));

`ifndef TBUF_BUS_PARK_EN
        // Asynchronous reset while requester 2 drives: no edge in between.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.gnt",  32'(bus_if.gnt),     32'h0);
        chk("arst.en",   32'(bus_if.tbuf_en), 32'h0);
        chk("arst.oen",  32'(bus_if.pad_oen), 32'h1);
        chk("arst.busy", 32'(bus_if.busy),    32'h0);
        step('{1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0}, "arst_hold");
        step('{1'b1, 4'b0100, 4'b0100, 4'b0100, 1'b0, 1'b1, 2'd2}, "arst_rel");
`endif

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard: left=%0d expected 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
